// File: rtl/symbol_storage_arbiter_if.sv
// symbol_storage_arbiter_if
//   Bundles every handshake/bus signal of the symbol RAM arbiter: the i/q
//   symbol FIFO pop side, the SPI address / write-data FIFO pop sides, the
//   read-return FIFO push side, the single-port RAM bus and the ring status.
//   master : arbiter side (drives pop/push strobes, RAM bus, status)
//   slave  : environment side (FIFOs, RAM, SPI level)
interface symbol_storage_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int PTR_W  = 8
);
  logic              i_q_data_fifo_empty;
  logic [7:0]        i_q_data;
  logic              i_q_data_fifo_read_enable;
  logic              reg_addr_fifo_empty;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_addr_fifo_read_enable;
  logic              spi_write_req;
  logic              write_data_fifo_empty;
  logic [DATA_W-1:0] write_data;
  logic              write_data_fifo_read_enable;
  logic              read_data_fifo_full;
  logic [DATA_W-1:0] read_data;
  logic              read_data_fifo_write_enable;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [PTR_W-1:0]  sym_wr_ptr;
  logic              sym_wrapped;
  logic              busy;

  modport master (
    input  i_q_data_fifo_empty, i_q_data, reg_addr_fifo_empty, reg_addr,
           spi_write_req, write_data_fifo_empty, write_data,
           read_data_fifo_full, mem_rdata,
    output i_q_data_fifo_read_enable, reg_addr_fifo_read_enable,
           write_data_fifo_read_enable, read_data, read_data_fifo_write_enable,
           mem_en, mem_we, mem_addr, mem_wdata, sym_wr_ptr, sym_wrapped, busy
  );

  modport slave (
    output i_q_data_fifo_empty, i_q_data, reg_addr_fifo_empty, reg_addr,
           spi_write_req, write_data_fifo_empty, write_data,
           read_data_fifo_full, mem_rdata,
    input  i_q_data_fifo_read_enable, reg_addr_fifo_read_enable,
           write_data_fifo_read_enable, read_data, read_data_fifo_write_enable,
           mem_en, mem_we, mem_addr, mem_wdata, sym_wr_ptr, sym_wrapped, busy
  );
endinterface

// File: rtl/symbol_storage_arbiter.sv
// symbol_storage_arbiter
//   Sequences all accesses to the single-port symbol RAM. Two requesters:
//   baseband symbols (written into a ring region starting at SYM_BASE) and
//   SPI register reads/writes (whole address space). Round-robin between
//   the two; one operation in flight at a time.
// Ports:
//   sym_clk : clock
//   rst     : asynchronous reset, active-high
//   bus     : symbol_storage_arbiter_if.master (FIFO strobes, RAM bus, status)
module symbol_storage_arbiter #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] SYM_BASE  = 10'h100,
  parameter int                SYM_DEPTH = 256
) (
  input  logic                    sym_clk,
  input  logic                    rst,
  symbol_storage_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(SYM_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYM_WR  = 3'd1;
  localparam logic [2:0] SPI_WR  = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RD_PUSH = 3'd5;

  localparam logic GNT_SYM = 1'b0;
  localparam logic GNT_SPI = 1'b1;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_last_grant;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_wrapped;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;
  logic [DATA_W-1:0] r_read_data;

  logic              w_idle;
  logic              w_sym_req;
  logic              w_spi_wr_req;
  logic              w_spi_rd_req;
  logic              w_spi_req;
  logic              w_gnt_sym;
  logic              w_gnt_spi;
  logic              w_gnt_spi_wr;
  logic              w_gnt_spi_rd;
  logic [ADDR_W-1:0] w_sym_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_mem_en;
  logic              w_mem_we;

  // Gating with rst keeps pop strobes quiet while reset is held, even though
  // the FSM already sits in IDLE with requests pending.
  assign w_idle       = (r_state == IDLE) && !rst;
  assign w_sym_req    = !bus.i_q_data_fifo_empty;
  assign w_spi_wr_req = !bus.reg_addr_fifo_empty &&  bus.spi_write_req && !bus.write_data_fifo_empty;
  assign w_spi_rd_req = !bus.reg_addr_fifo_empty && !bus.spi_write_req && !bus.read_data_fifo_full;
  assign w_spi_req    = w_spi_wr_req || w_spi_rd_req;

  // On a tie the side not granted last time wins.
  assign w_gnt_sym    = w_idle && w_sym_req && (!w_spi_req || (r_last_grant == GNT_SPI));
  assign w_gnt_spi    = w_idle && w_spi_req && (!w_sym_req || (r_last_grant == GNT_SYM));
  assign w_gnt_spi_wr = w_gnt_spi && bus.spi_write_req;
  assign w_gnt_spi_rd = w_gnt_spi && !bus.spi_write_req;

  assign w_sym_addr   = SYM_BASE + ADDR_W'(r_ptr);

  always_comb begin
    w_next      = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr_hold;
    w_mem_wdata = r_wdata_hold;
    case (r_state)
      IDLE: begin
        if (w_gnt_sym)         w_next = SYM_WR;
        else if (w_gnt_spi_wr) w_next = SPI_WR;
        else if (w_gnt_spi_rd) w_next = RD_ADDR;
      end
      // FIFO data is valid the cycle after its pop, so the RAM bus is fed
      // straight from the FIFO outputs here and captured for hold afterwards.
      SYM_WR: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = w_sym_addr;
        w_mem_wdata = DATA_W'(bus.i_q_data);
        w_next      = IDLE;
      end
      SPI_WR: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = bus.reg_addr;
        w_mem_wdata = bus.write_data;
        w_next      = IDLE;
      end
      RD_ADDR: begin
        w_mem_en   = 1'b1;
        w_mem_addr = bus.reg_addr;
        w_next     = RD_DATA;
      end
      RD_DATA: w_next = RD_PUSH;
      RD_PUSH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sym_clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_SPI;
      r_ptr        <= '0;
      r_wrapped    <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_read_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_sym) r_last_grant <= GNT_SYM;
      if (w_gnt_spi) r_last_grant <= GNT_SPI;
      if (w_mem_en)  r_addr_hold  <= w_mem_addr;
      if (w_mem_we)  r_wdata_hold <= w_mem_wdata;
      if (r_state == SYM_WR) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == '1) r_wrapped <= 1'b1;
      end
      if (r_state == RD_DATA) r_read_data <= bus.mem_rdata;
    end
  end

  assign bus.i_q_data_fifo_read_enable   = w_gnt_sym;
  assign bus.reg_addr_fifo_read_enable   = w_gnt_spi;
  assign bus.write_data_fifo_read_enable = w_gnt_spi_wr;
  assign bus.read_data_fifo_write_enable = (r_state == RD_PUSH);
  assign bus.read_data                   = r_read_data;
  assign bus.mem_en                      = w_mem_en;
  assign bus.mem_we                      = w_mem_we;
  assign bus.mem_addr                    = w_mem_addr;
  assign bus.mem_wdata                   = w_mem_wdata;
  assign bus.sym_wr_ptr                  = r_ptr;
  assign bus.sym_wrapped                 = r_wrapped;
  assign bus.busy                        = (r_state != IDLE);
endmodule

// File: tb/tb_symbol_storage_arbiter.sv
module tb_symbol_storage_arbiter;
  logic sym_clk;
  logic rst;

  symbol_storage_arbiter_if #(.ADDR_W(10), .DATA_W(8), .PTR_W(8)) io ();

  symbol_storage_arbiter #(
    .ADDR_W(10), .DATA_W(8), .SYM_BASE(10'h100), .SYM_DEPTH(256)
  ) dut (
    .sym_clk(sym_clk),
    .rst    (rst),
    .bus    (io.master)
  );

  initial sym_clk = 1'b0;
  always #5 sym_clk = ~sym_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // FIFO contents and RAM owned by the bench
  logic [7:0] iq_q[$];
  logic [9:0] ra_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] ram [0:1023];

  // event logs
  int         gnt_q[$];   // 0 = symbol, 1 = SPI
  int         gc_q[$];    // grant cycle
  logic [9:0] wa_q[$];
  logic [7:0] wdl_q[$];
  int         wc_q[$];
  logic [7:0] rd_q[$];
  int         rc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    io.i_q_data_fifo_empty   = (iq_q.size() == 0);
    io.reg_addr_fifo_empty   = (ra_q.size() == 0);
    io.write_data_fifo_empty = (wd_q.size() == 0);
  endtask

  task automatic clear_logs();
    gnt_q.delete(); gc_q.delete(); wa_q.delete(); wdl_q.delete();
    wc_q.delete(); rd_q.delete(); rc_q.delete();
  endtask

  // One clock cycle: starts 1 time unit after a rising edge, samples the
  // cycle's outputs just before the falling edge, then after the next rising
  // edge updates the FIFO/RAM models.
  task automatic step();
    logic s_iq, s_ra, s_wd, s_rp, s_en, s_we;
    logic [9:0] s_a;
    logic [7:0] s_d, s_rd;
    #3;
    s_iq = io.i_q_data_fifo_read_enable;
    s_ra = io.reg_addr_fifo_read_enable;
    s_wd = io.write_data_fifo_read_enable;
    s_rp = io.read_data_fifo_write_enable;
    s_en = io.mem_en;
    s_we = io.mem_we;
    s_a  = io.mem_addr;
    s_d  = io.mem_wdata;
    s_rd = io.read_data;
    if (s_iq) begin gnt_q.push_back(0); gc_q.push_back(cyc); end
    if (s_ra) begin gnt_q.push_back(1); gc_q.push_back(cyc); end
    if (s_en && s_we) begin
      wa_q.push_back(s_a); wdl_q.push_back(s_d); wc_q.push_back(cyc);
    end
    if (s_rp) begin rd_q.push_back(s_rd); rc_q.push_back(cyc); end
    @(posedge sym_clk);
    #1;
    if (s_en && s_we) ram[s_a] = s_d;
    if (s_en && !s_we) io.mem_rdata = ram[s_a];
    if (s_iq && iq_q.size() != 0) io.i_q_data   = iq_q.pop_front();
    if (s_ra && ra_q.size() != 0) io.reg_addr   = ra_q.pop_front();
    if (s_wd && wd_q.size() != 0) io.write_data = wd_q.pop_front();
    upd_flags();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  logic [7:0] sym_v [4];
  logic [7:0] spd_v [4];
  logic [7:0] exp_d;

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 8'h00;
    rst = 1'b1;
    io.i_q_data = 8'h00; io.reg_addr = 10'h000; io.write_data = 8'h00;
    io.spi_write_req = 1'b0; io.read_data_fifo_full = 1'b0; io.mem_rdata = 8'h00;
    upd_flags();
    #6;

    // ---------------- reset state
    chk("rst_mem_en",   {31'd0, io.mem_en}, 32'd0);
    chk("rst_mem_we",   {31'd0, io.mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, io.mem_addr}, 32'd0);
    chk("rst_wdata",    {24'd0, io.mem_wdata}, 32'd0);
    chk("rst_rdata",    {24'd0, io.read_data}, 32'd0);
    chk("rst_ptr",      {24'd0, io.sym_wr_ptr}, 32'd0);
    chk("rst_wrapped",  {31'd0, io.sym_wrapped}, 32'd0);
    chk("rst_busy",     {31'd0, io.busy}, 32'd0);
    rst = 1'b0;
    run(2);

    // ---------------- symbols only
    clear_logs();
    iq_q.push_back(8'hA5); iq_q.push_back(8'h3C); iq_q.push_back(8'hF0); upd_flags();
    run(8);
    chk("sym_nwr", wa_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sym_addr%0d", i), (i < wa_q.size()) ? {22'd0, wa_q[i]} : 'x, 32'h100 + i);
    end
    chk("sym_d0", (wdl_q.size() > 0) ? {24'd0, wdl_q[0]} : 'x, 32'hA5);
    chk("sym_d1", (wdl_q.size() > 1) ? {24'd0, wdl_q[1]} : 'x, 32'h3C);
    chk("sym_d2", (wdl_q.size() > 2) ? {24'd0, wdl_q[2]} : 'x, 32'hF0);
    chk("sym_gap01", (wc_q.size() > 1) ? wc_q[1] - wc_q[0] : -1, 2);
    chk("sym_gap12", (wc_q.size() > 2) ? wc_q[2] - wc_q[1] : -1, 2);
    chk("sym_lat", (wc_q.size() > 0 && gc_q.size() > 0) ? wc_q[0] - gc_q[0] : -1, 1);
    chk("sym_ptr3", {24'd0, io.sym_wr_ptr}, 32'd3);

    // ---------------- SPI write then read of 0x005
    clear_logs();
    io.spi_write_req = 1'b1;
    ra_q.push_back(10'h005); wd_q.push_back(8'h5A); upd_flags();
    run(4);
    chk("spiwr_n",    wa_q.size(), 1);
    chk("spiwr_addr", (wa_q.size() > 0) ? {22'd0, wa_q[0]} : 'x, 32'h005);
    chk("spiwr_data", (wdl_q.size() > 0) ? {24'd0, wdl_q[0]} : 'x, 32'h5A);
    chk("spiwr_ptr",  {24'd0, io.sym_wr_ptr}, 32'd3);
    clear_logs();
    io.spi_write_req = 1'b0;
    ra_q.push_back(10'h005); upd_flags();
    run(6);
    chk("spird_n",    rd_q.size(), 1);
    chk("spird_data", (rd_q.size() > 0) ? {24'd0, rd_q[0]} : 'x, 32'h5A);
    chk("spird_lat",  (rc_q.size() > 0 && gc_q.size() > 0) ? rc_q[0] - gc_q[0] : -1, 3);
    chk("spird_nowr", wa_q.size(), 0);

    // ---------------- reset in the middle of SYM_WR
    clear_logs();
    iq_q.push_back(8'h77); upd_flags();
    step();
    chk("mid_pre_en", {31'd0, io.mem_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_mem_en",   {31'd0, io.mem_en}, 32'd0);
    chk("mid_mem_we",   {31'd0, io.mem_we}, 32'd0);
    chk("mid_mem_addr", {22'd0, io.mem_addr}, 32'd0);
    chk("mid_wdata",    {24'd0, io.mem_wdata}, 32'd0);
    chk("mid_rdata",    {24'd0, io.read_data}, 32'd0);
    chk("mid_ptr",      {24'd0, io.sym_wr_ptr}, 32'd0);
    chk("mid_busy",     {31'd0, io.busy}, 32'd0);
    @(posedge sym_clk);
    #1;
    chk("mid_we_after", {31'd0, io.mem_we}, 32'd0);
    chk("mid_ram103",   {24'd0, ram[10'h103]}, 32'd0);
    rst = 1'b0;

    // ---------------- contention, symbol first after reset
    clear_logs();
    sym_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    spd_v = '{8'h81, 8'h82, 8'h83, 8'h84};
    io.spi_write_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iq_q.push_back(sym_v[i]); ra_q.push_back(10'h010 + 10'(i)); wd_q.push_back(spd_v[i]);
    end
    upd_flags();
    run(18);
    chk("cont_ngnt", gnt_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_gnt%0d", i), (i < gnt_q.size()) ? gnt_q[i] : -1, i % 2);
      chk($sformatf("cont_addr%0d", i), (i < wa_q.size()) ? {22'd0, wa_q[i]} : 'x,
          (i % 2 == 0) ? 32'h100 + i / 2 : 32'h010 + i / 2);
      chk($sformatf("cont_data%0d", i), (i < wdl_q.size()) ? {24'd0, wdl_q[i]} : 'x,
          (i % 2 == 0) ? {24'd0, sym_v[i / 2]} : {24'd0, spd_v[i / 2]});
    end

    // ---------------- back-pressure: read-return FIFO full
    clear_logs();
    io.spi_write_req = 1'b0;
    io.read_data_fifo_full = 1'b1;
    ra_q.push_back(10'h005); iq_q.push_back(8'h55); iq_q.push_back(8'h66); upd_flags();
    run(8);
    chk("bpf_ngnt", gnt_q.size(), 2);
    chk("bpf_g0",   (gnt_q.size() > 0) ? gnt_q[0] : -1, 0);
    chk("bpf_g1",   (gnt_q.size() > 1) ? gnt_q[1] : -1, 0);
    chk("bpf_nrd",  rd_q.size(), 0);
    chk("bpf_a1",   (wa_q.size() > 1) ? {22'd0, wa_q[1]} : 'x, 32'h105);
    clear_logs();
    io.read_data_fifo_full = 1'b0;
    run(6);
    chk("bpf_rd_n",    rd_q.size(), 1);
    chk("bpf_rd_data", (rd_q.size() > 0) ? {24'd0, rd_q[0]} : 'x, 32'h5A);

    // ---------------- back-pressure: write pending without data
    clear_logs();
    io.spi_write_req = 1'b1;
    ra_q.push_back(10'h020); upd_flags();
    run(5);
    chk("bpw_ngnt", gnt_q.size(), 0);
    chk("bpw_busy", {31'd0, io.busy}, 32'd0);
    wd_q.push_back(8'hC3); upd_flags();
    run(4);
    chk("bpw_nwr",  wa_q.size(), 1);
    chk("bpw_addr", (wa_q.size() > 0) ? {22'd0, wa_q[0]} : 'x, 32'h020);
    chk("bpw_data", (wdl_q.size() > 0) ? {24'd0, wdl_q[0]} : 'x, 32'hC3);
    io.spi_write_req = 1'b0;

    // ---------------- ring wrap
    rst = 1'b1;
    @(posedge sym_clk);
    #1 rst = 1'b0;
    chk("wrap_ptr0", {24'd0, io.sym_wr_ptr}, 32'd0);
    chk("wrap_flag0", {31'd0, io.sym_wrapped}, 32'd0);
    clear_logs();
    for (int i = 0; i < 256; i++) iq_q.push_back(8'((i * 7 + 3) & 8'hFF));
    upd_flags();
    run(516);
    chk("wrap_n256",  wa_q.size(), 256);
    chk("wrap_last",  (wa_q.size() > 255) ? {22'd0, wa_q[255]} : 'x, 32'h1FF);
    chk("wrap_ptr_a", {24'd0, io.sym_wrapped ? io.sym_wr_ptr : 8'hEE}, 32'd0);
    chk("wrap_flag1", {31'd0, io.sym_wrapped}, 32'd1);
    clear_logs();
    exp_d = 8'((256 * 7 + 3) & 8'hFF);
    iq_q.push_back(exp_d); upd_flags();
    run(4);
    chk("wrap257_addr", (wa_q.size() > 0) ? {22'd0, wa_q[0]} : 'x, 32'h100);
    chk("wrap257_data", (wdl_q.size() > 0) ? {24'd0, wdl_q[0]} : 'x, {24'd0, exp_d});
    chk("wrap257_ptr",  {24'd0, io.sym_wr_ptr}, 32'd1);
    chk("wrap257_flag", {31'd0, io.sym_wrapped}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/symbol_storage_arbiter.md
Name: symbol_storage_arbiter

Overview:
- Sequences all accesses to the single-port symbol RAM in the sym_clk domain.
- Has two requesters:
  - baseband symbols, from the i/q CDC FIFO;
  - SPI register reads and writes, from the reg_addr and write_data CDC FIFOs, with read results returned through the read_data CDC FIFO.
- Symbols go into a ring region of the RAM. SPI reaches the whole address space.
- Round-robin arbitration between the two requesters prevents starvation.

Parameters:
- ADDR_W, 10: RAM and reg_addr address width.
- DATA_W, 8: RAM word width. One symbol word is {i[3:0], q[3:0]}.
- SYM_BASE, 10'h100: first RAM address of the symbol ring.
- SYM_DEPTH, 256: ring length in words. Must be a power of 2, and SYM_BASE+SYM_DEPTH must not exceed 2^ADDR_W.

Ports:
- sym_clk  in  1  Clock.
- rst  in  1  Asynchronous reset, active-high.
- i_q_data_fifo_empty  in  1  i/q FIFO empty.
- i_q_data  in  8  {i,q} word. Valid the cycle after the pop.
- i_q_data_fifo_read_enable  out  1  Pop strobe for the i/q FIFO.
- reg_addr_fifo_empty  in  1  SPI address FIFO empty.
- reg_addr  in  ADDR_W  SPI address. Valid the cycle after the pop.
- reg_addr_fifo_read_enable  out  1  Pop strobe for the address FIFO.
- spi_write_req  in  1  Synchronized SPI write-enable level. Selects the op type when an SPI grant is made.
- write_data_fifo_empty  in  1  Write-data FIFO empty.
- write_data  in  DATA_W  Write data. Valid the cycle after the pop.
- write_data_fifo_read_enable  out  1  Pop strobe for the write-data FIFO.
- read_data_fifo_full  in  1  Read-return FIFO full.
- read_data  out  DATA_W  Read result.
- read_data_fifo_write_enable  out  1  Push strobe for the read-return FIFO.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data. Valid one cycle after an mem_en=1, mem_we=0 cycle.
- sym_wr_ptr  out  log2(SYM_DEPTH)  Next ring offset to be written.
- sym_wrapped  out  1  Sticky flag: the ring has wrapped at least once.
- busy  out  1  High whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE. All strobes are 0.
  - mem_addr, mem_wdata, read_data, sym_wr_ptr = 0. sym_wrapped = 0.
  - last_grant is set to SPI, so a symbol wins the first tie.
  - An operation interrupted by reset is abandoned. Any popped FIFO word is lost and no RAM write completes.
- Request qualification, evaluated only in IDLE:
  - sym_req = !i_q_data_fifo_empty.
  - spi_wr_req = !reg_addr_fifo_empty & spi_write_req & !write_data_fifo_empty.
  - spi_rd_req = !reg_addr_fifo_empty & !spi_write_req & !read_data_fifo_full.
  - spi_req = spi_wr_req | spi_rd_req.
  - If spi_write_req=1 but write_data_fifo_empty=1, the SPI side does not request. It waits; it is never converted into a read.
- Arbitration:
  - If only one requester is pending, it wins.
  - If both are pending, the winner is the side not recorded in last_grant.
  - last_grant is updated on every grant.
- Grant cycle (still IDLE): pop strobes pulse for exactly 1 cycle.
  - Symbol grant: i_q_data_fifo_read_enable=1; go to SYM_WR.
  - SPI write grant: reg_addr_fifo_read_enable=1 and write_data_fifo_read_enable=1; go to SPI_WR.
  - SPI read grant: reg_addr_fifo_read_enable=1; go to RD_ADDR.
- SYM_WR (1 cycle):
  - mem_en=1, mem_we=1, mem_addr=SYM_BASE+sym_wr_ptr, mem_wdata=i_q_data.
  - sym_wr_ptr increments modulo SYM_DEPTH.
  - On the transition SYM_DEPTH-1 -> 0, sym_wrapped is set to 1.
  - Next state: IDLE.
- SPI_WR (1 cycle): mem_en=1, mem_we=1, mem_addr=reg_addr, mem_wdata=write_data. Next state: IDLE.
  - Writes inside the ring region are allowed and do not move sym_wr_ptr.
- RD_ADDR (1 cycle): mem_en=1, mem_we=0, mem_addr=reg_addr. Next state: RD_DATA.
- RD_DATA (1 cycle): read_data is loaded from mem_rdata. Next state: RD_PUSH.
- RD_PUSH (1 cycle): read_data_fifo_write_enable=1. Next state: IDLE.
  - The push cannot hit a full FIFO: full was checked at grant, and this block is the only writer.
- Latencies from grant to the RAM write or push:
  - Symbol: 1 cycle.
  - SPI write: 1 cycle.
  - SPI read: 3 cycles.
  - At most one operation is in flight. The next grant can occur in the IDLE cycle immediately after an operation returns.
- Outside an active RAM state, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- sym_wr_ptr arithmetic is unsigned, width log2(SYM_DEPTH), with natural wrap.

Test Plan:
- Reset: assert rst mid-SYM_WR.
  - Required: all outputs return to 0 asynchronously, with no mem_we pulse after rst.
  - Required after release: a pending symbol is granted first.
- Symbol only: 3 words 8'hA5, 8'h3C, 8'hF0 in the i/q FIFO.
  - Required: RAM writes to 10'h100, 10'h101, 10'h102 with those words.
  - Required: each write is 2 cycles apart; sym_wr_ptr ends at 3.
- SPI write then read of 10'h005.
  - Write: data 8'h5A is written at 10'h005.
  - Read: read_data=8'h5A and the push strobe occurs 3 cycles after the address pop.
- Contention: both FIFOs are continuously non-empty.
  - Required: grants alternate symbol, SPI, symbol, SPI, starting with symbol after reset, and neither side is starved.
- Ring wrap: 257 symbols with SYM_DEPTH=256.
  - Required: the 257th word is written to 10'h100, sym_wr_ptr=1, and sym_wrapped=1.
- Back-pressure:
  - read_data_fifo_full=1 with a read pending: no read grant; symbols are still served.
  - spi_write_req=1 with the write-data FIFO empty: no SPI grant until data arrives.
